// File: rtl/fcs16_chk.sv
// Receive-side FCS-16 (CRC-16/USB) checker: strips the trailing two FCS bytes,
// forwards the payload with a two-byte hold-off and reports per-frame status.
module fcs16_chk #(
   parameter int MIN_PLD       = 1,
   parameter int MAX_PLD       = 1024,
   parameter bit FCS_MSB_FIRST = 1'b1
) (
   input  logic        clk_sys,
   input  logic        rst_sys,
   input  logic [7:0]  rx_din,
   input  logic        rx_sop,
   input  logic        rx_eop,
   input  logic        rx_din_vld,
   output logic [7:0]  pld_dout,
   output logic        pld_sop,
   output logic        pld_eop,
   output logic        pld_vld,
   output logic        chk_done,
   output logic        chk_ok,
   output logic [2:0]  chk_err,
   output logic [15:0] ok_cnt,
   output logic [15:0] err_cnt
);

   localparam int             CW      = $clog2(MAX_PLD + 4);
   localparam logic [CW-1:0]  CNT_SAT = CW'(MAX_PLD + 3);
   localparam logic [CW-1:0]  CNT_EMT = CW'(MAX_PLD + 2);
   localparam logic [CW-1:0]  CNT_MIN = CW'(MIN_PLD);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_PLD);

   typedef enum logic [0:0] {IDLE = 1'b0, RCV = 1'b1} state_t;

   // Register kept in non-reflected form; data bits enter LSB first, so the
   // reflected result is the bit-reversed complement of this register.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
      return c;
   endfunction

   function automatic logic [15:0] bitrev16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) begin
         r[i] = v[15-i];
      end
      return r;
   endfunction

   state_t        state_q, state_d;
   logic [7:0]    hold0_q, hold0_d, hold1_q, hold1_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   crc_q, crc_d;
   logic [7:0]    pld_dout_q, pld_dout_d;
   logic          pld_sop_q, pld_sop_d, pld_eop_q, pld_eop_d, pld_vld_q, pld_vld_d;
   logic          chk_done_q, chk_done_d, chk_ok_q, chk_ok_d;
   logic [2:0]    chk_err_q, chk_err_d;
   logic [15:0]   ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;

   logic          is_pld_s, emit_s, len_bad_s, crc_bad_s;
   logic [15:0]   crc_fin_s, fcs_s, expected_s;
   logic [CW-1:0] pld_count_s;

   // Frame arithmetic on the current beat: payload accounting, CRC and FCS compare.
   always_comb begin
      is_pld_s    = (cnt_q >= CW'(2));
      emit_s      = is_pld_s && (cnt_q < CNT_EMT);
      crc_fin_s   = is_pld_s ? crc16_byte(crc_q, hold1_q) : crc_q;
      expected_s  = bitrev16(~crc_fin_s);
      fcs_s       = FCS_MSB_FIRST ? {hold0_q, rx_din} : {rx_din, hold0_q};
      pld_count_s = cnt_q - CW'(1);
      len_bad_s   = (pld_count_s < CNT_MIN) || (pld_count_s > CNT_MAX);
      crc_bad_s   = (expected_s != fcs_s);
   end

   // Next-state and next-output logic for the framing FSM and counters.
   always_comb begin
      state_d    = state_q;
      hold0_d    = hold0_q;
      hold1_d    = hold1_q;
      cnt_d      = cnt_q;
      crc_d      = crc_q;
      pld_dout_d = pld_dout_q;
      pld_sop_d  = 1'b0;
      pld_eop_d  = 1'b0;
      pld_vld_d  = 1'b0;
      chk_done_d = 1'b0;
      chk_ok_d   = 1'b0;
      chk_err_d  = 3'b000;
      ok_cnt_d   = ok_cnt_q;
      err_cnt_d  = err_cnt_q;

      case (state_q)
         IDLE: begin
            if (rx_din_vld && rx_sop) begin
               if (rx_eop) begin
                  chk_done_d = 1'b1;
                  chk_err_d  = 3'b100;
               end else begin
                  hold0_d = rx_din;
                  cnt_d   = CW'(1);
                  crc_d   = 16'hFFFF;
                  state_d = RCV;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RCV: begin
            if (!rx_din_vld) begin
               state_d = RCV;
            end else if (rx_sop) begin
               // Abort: the new sop byte restarts framing in the same cycle.
               chk_done_d = 1'b1;
               chk_err_d  = 3'b010;
               hold0_d    = rx_din;
               cnt_d      = CW'(1);
               crc_d      = 16'hFFFF;
               state_d    = rx_eop ? IDLE : RCV;
            end else begin
               if (emit_s) begin
                  pld_vld_d  = 1'b1;
                  pld_dout_d = hold1_q;
                  pld_sop_d  = (cnt_q == CW'(2));
                  pld_eop_d  = rx_eop;
               end else begin
                  pld_vld_d = 1'b0;
               end
               if (rx_eop) begin
                  // An empty payload is compared against the CRC of an empty message.
                  chk_done_d = 1'b1;
                  chk_err_d  = {len_bad_s, 1'b0, crc_bad_s};
                  chk_ok_d   = !len_bad_s && !crc_bad_s;
                  cnt_d      = '0;
                  crc_d      = 16'hFFFF;
                  state_d    = IDLE;
               end else begin
                  hold1_d = hold0_q;
                  hold0_d = rx_din;
                  crc_d   = crc_fin_s;
                  cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (chk_done_d) begin
         if (chk_ok_d) begin
            ok_cnt_d = (ok_cnt_q == 16'hFFFF) ? ok_cnt_q : ok_cnt_q + 16'd1;
         end else begin
            err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
         end
      end else begin
         ok_cnt_d = ok_cnt_q;
      end
   end

   // State, hold and output registers.
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         state_q    <= IDLE;
         hold0_q    <= 8'h00;
         hold1_q    <= 8'h00;
         cnt_q      <= '0;
         crc_q      <= 16'hFFFF;
         pld_dout_q <= 8'h00;
         pld_sop_q  <= 1'b0;
         pld_eop_q  <= 1'b0;
         pld_vld_q  <= 1'b0;
         chk_done_q <= 1'b0;
         chk_ok_q   <= 1'b0;
         chk_err_q  <= 3'b000;
         ok_cnt_q   <= 16'h0000;
         err_cnt_q  <= 16'h0000;
      end else begin
         state_q    <= state_d;
         hold0_q    <= hold0_d;
         hold1_q    <= hold1_d;
         cnt_q      <= cnt_d;
         crc_q      <= crc_d;
         pld_dout_q <= pld_dout_d;
         pld_sop_q  <= pld_sop_d;
         pld_eop_q  <= pld_eop_d;
         pld_vld_q  <= pld_vld_d;
         chk_done_q <= chk_done_d;
         chk_ok_q   <= chk_ok_d;
         chk_err_q  <= chk_err_d;
         ok_cnt_q   <= ok_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign pld_dout = pld_dout_q;
   assign pld_sop  = pld_sop_q;
   assign pld_eop  = pld_eop_q;
   assign pld_vld  = pld_vld_q;
   assign chk_done = chk_done_q;
   assign chk_ok   = chk_ok_q;
   assign chk_err  = chk_err_q;
   assign ok_cnt   = ok_cnt_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_fcs16_chk.sv
// Self-checking bench for fcs16_chk: table of frames plus hand-written
// gap/abort/length/saturation/reset sequences, checked through a scoreboard.
module tb_fcs16_chk;

   logic        clk_sys = 1'b0;
   logic        rst_sys;
   logic [7:0]  rx_din;
   logic        rx_sop, rx_eop, rx_din_vld, b_en, vld_b;
   logic [7:0]  pld_dout, pld_dout_b;
   logic        pld_sop, pld_eop, pld_vld, chk_done, chk_ok;
   logic        pld_sop_b, pld_eop_b, pld_vld_b, chk_done_b, chk_ok_b;
   logic [2:0]  chk_err, chk_err_b;
   logic [15:0] ok_cnt, err_cnt, ok_cnt_b, err_cnt_b;

   always #5 clk_sys = ~clk_sys;
   assign vld_b = rx_din_vld & b_en;

   fcs16_chk #(.MIN_PLD(1), .MAX_PLD(1024), .FCS_MSB_FIRST(1'b1)) dut (
      .clk_sys(clk_sys), .rst_sys(rst_sys), .rx_din(rx_din), .rx_sop(rx_sop),
      .rx_eop(rx_eop), .rx_din_vld(rx_din_vld), .pld_dout(pld_dout), .pld_sop(pld_sop),
      .pld_eop(pld_eop), .pld_vld(pld_vld), .chk_done(chk_done), .chk_ok(chk_ok),
      .chk_err(chk_err), .ok_cnt(ok_cnt), .err_cnt(err_cnt));

   fcs16_chk #(.MIN_PLD(1), .MAX_PLD(1024), .FCS_MSB_FIRST(1'b0)) dut_b (
      .clk_sys(clk_sys), .rst_sys(rst_sys), .rx_din(rx_din), .rx_sop(rx_sop),
      .rx_eop(rx_eop), .rx_din_vld(vld_b), .pld_dout(pld_dout_b), .pld_sop(pld_sop_b),
      .pld_eop(pld_eop_b), .pld_vld(pld_vld_b), .chk_done(chk_done_b), .chk_ok(chk_ok_b),
      .chk_err(chk_err_b), .ok_cnt(ok_cnt_b), .err_cnt(err_cnt_b));

   typedef struct { logic [7:0] d; logic s; logic e; } pld_t;
   typedef struct { logic ok; logic [2:0] err; } res_t;
   typedef struct {
      logic [11:0][7:0] b;
      int               len;
      logic             a_ok;
      logic [2:0]       a_err;
      logic             b_ok;
      logic [2:0]       b_err;
   } vec_t;

   pld_t        qp[$];
   res_t        qr[$];
   res_t        qrb[$];
   logic [7:0]  frm[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          gap_pct = 0;
   logic [15:0] exp_ok = 16'h0000;
   logic [15:0] exp_err = 16'h0000;
   int          exp_okb = 0;
   int          exp_errb = 0;
   vec_t        tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reflected-form reference CRC-16/USB over the current frame buffer.
   function automatic logic [15:0] model_crc();
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (frm[i]) begin
         c ^= {8'h00, frm[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic push_res(input logic ok, input logic [2:0] err);
      res_t r;
      r.ok = ok; r.err = err;
      qr.push_back(r);
      if (ok) begin
         if (exp_ok != 16'hFFFF) exp_ok = exp_ok + 16'd1;
      end else begin
         if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      end
   endtask

   task automatic beat(input logic [7:0] d, input logic s, input logic e);
      while ($urandom_range(99) < gap_pct) begin
         @(posedge clk_sys); #1;
      end
      rx_din = d; rx_sop = s; rx_eop = e; rx_din_vld = 1'b1;
      @(posedge clk_sys); #1;
      rx_din_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
   endtask

   // Push expected payload beats and result, then drive the frame in frm.
   task automatic send_frame(input logic do_eop, input logic ok, input logic [2:0] err);
      int   n;
      pld_t p;
      n = frm.size();
      for (int i = 0; i < n - 2; i++) begin
         if (i < 1024) begin
            p.d = frm[i]; p.s = (i == 0); p.e = do_eop && (i == n - 3);
            qp.push_back(p);
         end
      end
      if (do_eop) push_res(ok, err);
      else        push_res(1'b0, 3'b010);
      for (int i = 0; i < n; i++) beat(frm[i], i == 0, do_eop && (i == n - 1));
   endtask

   task automatic make_good(input int plen);
      logic [15:0] c;
      frm.delete();
      for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
      c = model_crc();
      frm.push_back(c[15:8]);
      frm.push_back(c[7:0]);
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 50 && (qp.size() + qr.size() + qrb.size()) != 0; t++) @(negedge clk_sys);
      chk(name, qp.size() + qr.size() + qrb.size(), 0);
   endtask

   // Scoreboard monitor: compares DUT outputs on the falling edge.
   always @(negedge clk_sys) begin
      pld_t pe;
      res_t re;
      if (pld_vld) begin
         if (qp.size() == 0) chk("pld_unexpected", 32'd1, 32'd0);
         else begin
            pe = qp.pop_front();
            chk("pld_beat", {pld_dout, pld_sop, pld_eop}, {pe.d, pe.s, pe.e});
         end
      end
      if (chk_done) begin
         if (qr.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
         else begin
            re = qr.pop_front();
            chk("result", {chk_ok, chk_err}, {re.ok, re.err});
         end
      end
      if (chk_done_b) begin
         if (qrb.size() == 0) chk("res_b_unexpected", 32'd1, 32'd0);
         else begin
            re = qrb.pop_front();
            chk("result_b", {chk_ok_b, chk_err_b}, {re.ok, re.err});
         end
      end
      if (pld_vld_b) chk("pld_b_beat", {pld_dout_b, pld_sop_b, pld_eop_b, pld_vld_b},
                         {pld_dout, pld_sop, pld_eop, pld_vld});
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_pld"}, {pld_dout, pld_sop, pld_eop, pld_vld}, 32'd0);
      chk({tag, "_stat"}, {chk_done, chk_ok, chk_err}, 32'd0);
      chk({tag, "_cnt"}, {ok_cnt, err_cnt}, 32'd0);
   endtask

   initial begin
      logic [15:0] c;
      res_t        rb;
      rst_sys = 1'b1; rx_din = 8'h00; rx_sop = 1'b0; rx_eop = 1'b0;
      rx_din_vld = 1'b0; b_en = 1'b1;

      for (int k = 0; k < 5; k++) begin
         tbl[k].b = '0;
         for (int j = 0; j < 9; j++) tbl[k].b[j] = 8'h31 + 8'(j);
      end
      tbl[0].len = 11; tbl[0].b[9] = 8'hB4; tbl[0].b[10] = 8'hC8;
      tbl[0].a_ok = 1'b1; tbl[0].a_err = 3'b000; tbl[0].b_ok = 1'b0; tbl[0].b_err = 3'b001;
      tbl[1].len = 11; tbl[1].b[9] = 8'hB4; tbl[1].b[10] = 8'hC9;
      tbl[1].a_ok = 1'b0; tbl[1].a_err = 3'b001; tbl[1].b_ok = 1'b0; tbl[1].b_err = 3'b001;
      tbl[2].len = 11; tbl[2].b[9] = 8'hC8; tbl[2].b[10] = 8'hB4;
      tbl[2].a_ok = 1'b0; tbl[2].a_err = 3'b001; tbl[2].b_ok = 1'b1; tbl[2].b_err = 3'b000;
      // Empty payload: FCS AABB/BBAA differs from the empty-message CRC 0000.
      tbl[3].len = 2; tbl[3].b[0] = 8'hAA; tbl[3].b[1] = 8'hBB;
      tbl[3].a_ok = 1'b0; tbl[3].a_err = 3'b101; tbl[3].b_ok = 1'b0; tbl[3].b_err = 3'b101;
      tbl[4].len = 1; tbl[4].b[0] = 8'h5A;
      tbl[4].a_ok = 1'b0; tbl[4].a_err = 3'b100; tbl[4].b_ok = 1'b0; tbl[4].b_err = 3'b100;

      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk_zero("reset");
      @(posedge clk_sys); #1;
      rst_sys = 1'b0;

      for (int k = 0; k < 5; k++) begin
         frm.delete();
         for (int j = 0; j < tbl[k].len; j++) frm.push_back(tbl[k].b[j]);
         rb.ok = tbl[k].b_ok; rb.err = tbl[k].b_err;
         qrb.push_back(rb);
         if (tbl[k].b_ok) exp_okb++;
         else             exp_errb++;
         send_frame(1'b1, tbl[k].a_ok, tbl[k].a_err);
      end
      drain("drain_table");
      chk("ok_cnt_table", ok_cnt, exp_ok);
      chk("err_cnt_table", err_cnt, exp_err);
      chk("ok_cnt_b", ok_cnt_b, 32'(exp_okb));
      chk("err_cnt_b", err_cnt_b, 32'(exp_errb));
      b_en = 1'b0;

      gap_pct = 40;
      frm.delete();
      for (int j = 0; j < 9; j++) frm.push_back(8'h31 + 8'(j));
      c = model_crc();
      chk("model_check_value", c, 16'hB4C8);
      frm.push_back(c[15:8]); frm.push_back(c[7:0]);
      send_frame(1'b1, 1'b1, 3'b000);
      make_good(8);
      while (frm.size() > 5) void'(frm.pop_back());
      send_frame(1'b0, 1'b0, 3'b010);
      make_good(20);
      send_frame(1'b1, 1'b1, 3'b000);
      make_good(1);
      send_frame(1'b1, 1'b1, 3'b000);
      gap_pct = 0;
      make_good(1024);
      send_frame(1'b1, 1'b1, 3'b000);
      make_good(1025);
      send_frame(1'b1, 1'b0, 3'b100);
      drain("drain_seq");
      chk("ok_cnt_seq", ok_cnt, exp_ok);
      chk("err_cnt_seq", err_cnt, exp_err);

      rst_sys = 1'b1;
      exp_ok = 16'h0000; exp_err = 16'h0000;
      @(negedge clk_sys);
      chk_zero("reset2");
      @(posedge clk_sys); #1;
      rst_sys = 1'b0;

      for (int i = 0; i < 65534; i++) begin
         push_res(1'b0, 3'b100);
         beat(8'h5A, 1'b1, 1'b1);
      end
      drain("drain_preload");
      chk("err_cnt_fffe", err_cnt, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         push_res(1'b0, 3'b100);
         beat(8'hA5, 1'b1, 1'b1);
      end
      drain("drain_sat");
      chk("err_cnt_sat", err_cnt, 16'hFFFF);
      chk("ok_cnt_sat", ok_cnt, 16'h0000);

      beat(8'h11, 1'b1, 1'b0);
      beat(8'h22, 1'b0, 1'b0);
      rst_sys = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         chk_zero("midframe_rst");
      end
      @(posedge clk_sys); #1;
      rst_sys = 1'b0;
      repeat (3) @(posedge clk_sys); #1;
      exp_ok = 16'h0000; exp_err = 16'h0000;
      make_good(4);
      send_frame(1'b1, 1'b1, 3'b000);
      drain("drain_final");
      chk("ok_cnt_final", ok_cnt, 16'h0001);
      chk("err_cnt_final", err_cnt, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
